// File: rtl/generador_evento_if.sv
// Event-generator signal bundle: button/enable inputs and toggle-event outputs.
// master drives the button side; slave is the generador_evento block.
interface generador_evento_if;
    logic       boton;
    logic       habilitado;
    logic       Entrada_out;
    logic       ocupado;
    logic       rechazado;
    logic [3:0] Contador_Eventos;

    modport master (
        output boton,
        output habilitado,
        input  Entrada_out,
        input  ocupado,
        input  rechazado,
        input  Contador_Eventos
    );

    modport slave (
        input  boton,
        input  habilitado,
        output Entrada_out,
        output ocupado,
        output rechazado,
        output Contador_Eventos
    );
endinterface

// File: rtl/generador_evento.sv
// Debounced push-button to toggle-encoded event generator with cooldown lockout.
// Optional auto-repeat while held: define GENERADOR_AUTOREPETIR_EN.
module generador_evento #(
    parameter int unsigned DEBOUNCE = 4,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned REPETIR  = 16
) (
    input  logic               clk,
    input  logic               B_reset,
    generador_evento_if.slave  ev
);

    if (DEBOUNCE < 1 || DEBOUNCE > 255) begin : g_chk_debounce
        $error("DEBOUNCE must be in 1..255");
    end
    if (COOLDOWN < 1 || COOLDOWN > 255) begin : g_chk_cooldown
        $error("COOLDOWN must be in 1..255");
    end
    if (REPETIR < 1 || REPETIR > 255) begin : g_chk_repetir
        $error("REPETIR must be in 1..255");
    end

    typedef enum logic [1:0] {
        REPOSO,
        FILTRO,
        PRESIONADO,
        ESPERA
    } estado_t;

    localparam logic [7:0] DEB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [7:0] COOL_LAST = 8'(COOLDOWN - 1);
`ifdef GENERADOR_AUTOREPETIR_EN
    localparam logic [7:0] REP_LAST  = 8'(REPETIR - 1);
`endif

    estado_t    estado, estado_n;
    logic [7:0] cnt, cnt_n;
    logic       disparo;

    logic       sync_a, s, s_prev;
    logic       salida;
    logic [3:0] contador;
    logic       rechazo;

    // Two-flop synchronizer; s_prev tracks s so cooldown presses are edge-detected.
    always_ff @(posedge clk or posedge B_reset) begin
        if (B_reset) begin
            sync_a <= 1'b0;
            s      <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            sync_a <= ev.boton;
            s      <= sync_a;
            s_prev <= s;
        end
    end

    always_ff @(posedge clk or posedge B_reset) begin
        if (B_reset) begin
            estado <= REPOSO;
            cnt    <= '0;
        end else begin
            estado <= estado_n;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        estado_n = estado;
        cnt_n    = cnt;
        disparo  = 1'b0;
        unique case (estado)
            REPOSO: begin
                cnt_n = '0;
                if (s && ev.habilitado) begin
                    estado_n = FILTRO;
                end
            end
            FILTRO: begin
                if (!s || !ev.habilitado) begin
                    estado_n = REPOSO;
                    cnt_n    = '0;
                end else if (cnt == DEB_LAST) begin
                    disparo  = 1'b1;
                    estado_n = PRESIONADO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            PRESIONADO: begin
                if (!s) begin
                    estado_n = ESPERA;
                    cnt_n    = '0;
                end
`ifdef GENERADOR_AUTOREPETIR_EN
                else if (cnt == REP_LAST) begin
                    disparo = 1'b1;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
`endif
            end
            ESPERA: begin
                if (cnt == COOL_LAST) begin
                    estado_n = REPOSO;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                estado_n = REPOSO;
                cnt_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge B_reset) begin
        if (B_reset) begin
            salida   <= 1'b0;
            contador <= '0;
            rechazo  <= 1'b0;
        end else begin
            if (disparo) begin
                salida   <= ~salida;
                contador <= contador + 4'd1;
            end
            rechazo <= (estado == ESPERA) && s && !s_prev;
        end
    end

    assign ev.Entrada_out      = salida;
    assign ev.Contador_Eventos = contador;
    assign ev.rechazado        = rechazo;
    assign ev.ocupado          = (estado == ESPERA);

endmodule

// File: tb/tb_generador_evento.sv
// Scoreboard bench for generador_evento: timestamp-based reference model feeds
// expected toggles/rejections into queues; a negedge monitor pops and compares.
module tb_generador_evento;
    localparam int unsigned DEB  = 4;
    localparam int unsigned COOL = 8;
    localparam int unsigned REP  = 16;
`ifdef GENERADOR_AUTOREPETIR_EN
    localparam bit          AUTOREP = 1'b1;
    localparam int unsigned HOLD60_TOGGLES = 4;
`else
    localparam bit          AUTOREP = 1'b0;
    localparam int unsigned HOLD60_TOGGLES = 1;
`endif

    logic clk = 1'b0;
    logic B_reset;

    generador_evento_if ev ();

    generador_evento #(
        .DEBOUNCE (DEB),
        .COOLDOWN (COOL),
        .REPETIR  (REP)
    ) dut (
        .clk     (clk),
        .B_reset (B_reset),
        .ev      (ev)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned edge_at;
        logic        nivel;
        logic [3:0]  cuenta;
    } tog_t;

    tog_t        tq[$];
    int unsigned rq[$];

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned edge_n = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t edge=%0d)", name, act, exp, $time, edge_n);
    endtask

    // Reference model: phases with start timestamps; s is the button value two edges back.
    typedef enum {M_IDLE, M_FILT, M_HELD, M_COOL} fase_t;
    fase_t       fase;
    int unsigned t0;
    logic        h1, h2, h3;
    logic        m_nivel;
    logic [3:0]  m_cuenta;

    task automatic emit();
        m_nivel  = ~m_nivel;
        m_cuenta = m_cuenta + 4'd1;
        tq.push_back('{edge_n, m_nivel, m_cuenta});
    endtask

    always @(posedge clk or posedge B_reset) begin
        logic sv, sp;
        if (B_reset) begin
            h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
            fase = M_IDLE; t0 = 0;
            m_nivel = 1'b0; m_cuenta = 4'd0;
            tq.delete(); rq.delete();
        end else begin
            edge_n++;
            sv = h2;
            sp = h3;
            case (fase)
                M_IDLE: if (sv && ev.habilitado) begin fase = M_FILT; t0 = edge_n; end
                M_FILT: begin
                    if (!sv || !ev.habilitado) fase = M_IDLE;
                    else if (edge_n - t0 == DEB) begin emit(); fase = M_HELD; t0 = edge_n; end
                end
                M_HELD: begin
                    if (!sv) begin fase = M_COOL; t0 = edge_n; end
                    else if (AUTOREP && edge_n - t0 == REP) begin emit(); t0 = edge_n; end
                end
                M_COOL: begin
                    if (sv && !sp) rq.push_back(edge_n);
                    if (edge_n - t0 == COOL) fase = M_IDLE;
                end
                default: fase = M_IDLE;
            endcase
            h3 = h2; h2 = h1; h1 = ev.boton;
        end
    end

    // Monitor
    logic        prev_out = 1'b0;
    int unsigned tog_cnt = 0, rej_cnt = 0, ocup_cnt = 0;
    int unsigned last_tog_edge = 0;

    always @(negedge clk) begin
        tog_t t;
        if (B_reset) begin
            chk("reset_Entrada_out", 32'(ev.Entrada_out), 0);
            chk("reset_Contador", 32'(ev.Contador_Eventos), 0);
            chk("reset_ocupado", 32'(ev.ocupado), 0);
            chk("reset_rechazado", 32'(ev.rechazado), 0);
            prev_out = 1'b0;
        end else begin
            if (ev.Entrada_out !== prev_out) begin
                tog_cnt++;
                last_tog_edge = edge_n;
                if (tq.size() == 0) begin
                    chk("toggle_pending", tq.size(), 1);
                end else begin
                    t = tq.pop_front();
                    chk("toggle_edge", edge_n, t.edge_at);
                    chk("toggle_level", 32'(ev.Entrada_out), 32'(t.nivel));
                    chk("toggle_count", 32'(ev.Contador_Eventos), 32'(t.cuenta));
                end
                prev_out = ev.Entrada_out;
            end
            if (tq.size() > 0 && tq[0].edge_at < edge_n) begin
                t = tq.pop_front();
                chk("toggle_missed", edge_n, t.edge_at);
            end
            if (ev.rechazado === 1'b1) begin
                rej_cnt++;
                if (rq.size() == 0) chk("rej_pending", rq.size(), 1);
                else chk("rej_edge", edge_n, rq.pop_front());
            end
            if (rq.size() > 0 && rq[0] < edge_n) chk("rej_missed", edge_n, rq.pop_front());
            if (ev.ocupado === 1'b1) ocup_cnt++;
            chk("ocupado", 32'(ev.ocupado), 32'(fase == M_COOL));
        end
    end

    task automatic hold(input logic b, input logic h, input int unsigned n);
        ev.boton      = b;
        ev.habilitado = h;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int unsigned n);
        B_reset = 1'b1;
        repeat (n) @(posedge clk);
        #2;
        B_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned p, e0, tc0;
        ev.boton = 1'b0;
        ev.habilitado = 1'b1;
        B_reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        B_reset = 1'b0;
        hold(0, 1, 3);

        // Single press: latency, one toggle, cooldown length
        p = edge_n + 1; tc0 = tog_cnt; ocup_cnt = 0;
        hold(1, 1, 20);
        hold(0, 1, 20);
        chk("press_latency", last_tog_edge - p + 1, DEB + 3);
        chk("press_toggles", tog_cnt - tc0, 1);
        chk("press_count", 32'(ev.Contador_Eventos), 1);
        chk("press_ocupado_cycles", ocup_cnt, COOL);

        // Glitches
        tc0 = tog_cnt;
        for (int i = 0; i < 10; i++) begin
            hold(1, 1, 1);
            hold(0, 1, 2);
        end
        hold(0, 1, 10);
        chk("glitch_toggles", tog_cnt - tc0, 0);
        chk("glitch_count", 32'(ev.Contador_Eventos), 1);

        // Press during cooldown
        tc0 = tog_cnt;
        hold(1, 1, 8);
        rej_cnt = 0; ocup_cnt = 0;
        hold(0, 1, 3);
        hold(1, 1, 10);
        hold(0, 1, 20);
        chk("cool_rej_pulses", rej_cnt, 1);
        chk("cool_ocupado_cycles", ocup_cnt, COOL);
        chk("cool_toggles", tog_cnt - tc0, 1);

        // Enable raised while held
        tc0 = tog_cnt;
        hold(1, 0, 15);
        chk("disabled_toggles", tog_cnt - tc0, 0);
        e0 = edge_n;
        hold(1, 1, 12);
        chk("enable_latency", last_tog_edge - e0, DEB + 1);
        hold(0, 1, 20);

        // Reset mid-debounce, button still held afterwards
        hold(1, 1, 4);
        do_reset(2);
        e0 = edge_n;
        hold(1, 1, 12);
        chk("reset_resync_latency", last_tog_edge - e0, DEB + 3);
        chk("reset_resync_count", 32'(ev.Contador_Eventos), 1);
        hold(0, 1, 20);

        // 17 presses wrap the counter
        do_reset(2);
        hold(0, 1, 3);
        for (int i = 0; i < 17; i++) begin
            hold(1, 1, 8);
            hold(0, 1, 14);
        end
        chk("wrap_Entrada_out", 32'(ev.Entrada_out), 1);
        chk("wrap_count", 32'(ev.Contador_Eventos), 1);

        // Long hold
        do_reset(2);
        tc0 = tog_cnt;
        hold(1, 1, 60);
        hold(0, 1, 20);
        chk("hold60_toggles", tog_cnt - tc0, HOLD60_TOGGLES);
        chk("hold60_count", 32'(ev.Contador_Eventos), HOLD60_TOGGLES);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 2));
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), $urandom_range(1, 25));
        end

        hold(0, 1, 30);
        chk("final_toggle_queue_empty", tq.size(), 0);
        chk("final_rej_queue_empty", rq.size(), 0);
        chk("final_Entrada_out", 32'(ev.Entrada_out), 32'(m_nivel));
        chk("final_count", 32'(ev.Contador_Eventos), 32'(m_cuenta));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
